// File: rtl/memory_access.sv
// Memory stage of the rv32 pipeline: performs the data-memory load/store for one
// executed instruction over a req/gnt/rvalid bus and presents a registered writeback beat.
module memory_access #(
  parameter int XLEN     = 32,
  parameter int RD_WIDTH = 5
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                src_tvalid,
  output logic                src_tready,
  input  logic                src_load,
  input  logic                src_store,
  input  logic [1:0]          src_size,
  input  logic                src_unsigned,
  input  logic [RD_WIDTH-1:0] src_rd,
  input  logic [XLEN-1:0]     src_alu,
  input  logic [XLEN-1:0]     src_rs2,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [3:0]          dmem_wstrb,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_tvalid,
  input  logic                wb_tready,
  output logic [RD_WIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_we,
  output logic                misaligned,
  output logic [XLEN-1:0]     bypass
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  logic [1:0]          state;

  // Instruction fields captured on accept, used while the bus access is in flight.
  logic                op_load;
  logic [1:0]          op_size;
  logic                op_unsigned;
  logic [RD_WIDTH-1:0] op_rd;
  logic [XLEN-1:0]     op_alu;

  logic                src_mem;
  logic                src_mis;
  logic                accept;

  logic                wb_load;
  logic [RD_WIDTH-1:0] wb_rd_nxt;
  logic [XLEN-1:0]     wb_data_nxt;
  logic                wb_we_nxt;
  logic                wb_mis_nxt;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] data;
    case (size)
      SZ_BYTE: data = {4{rs2[7:0]}};
      SZ_HALF: data = {2{rs2[15:0]}};
      default: data = rs2;
    endcase
    return data;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic uns,
                                                  input logic [1:0] off, input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] data;
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: data = {{(XLEN-8){~uns & lane[7]}}, lane[7:0]};
      SZ_HALF: data = {{(XLEN-16){~uns & lane[15]}}, lane[15:0]};
      default: data = lane;
    endcase
    return data;
  endfunction

  assign src_mem    = src_load | src_store;
  assign src_mis    = src_mem & is_misaligned(src_size, src_alu[1:0]);
  assign src_tready = (state == ST_IDLE) & (~wb_tvalid | wb_tready);
  assign accept     = src_tvalid & src_tready;
  assign bypass     = wb_data;

  // Selects which event, if any, loads a new writeback beat this edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wb_load     = 1'b0;
    wb_rd_nxt   = src_rd;
    wb_data_nxt = src_alu;
    wb_we_nxt   = 1'b0;
    wb_mis_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        wb_load    = accept & ~(src_mem & ~src_mis);
        wb_we_nxt  = ~src_mem & (src_rd != '0);
        wb_mis_nxt = src_mis;
      end
      ST_REQ: begin
        wb_load     = dmem_gnt & ~op_load;
        wb_rd_nxt   = op_rd;
        wb_data_nxt = op_alu;
      end
      ST_RESP: begin
        wb_load     = dmem_rvalid;
        wb_rd_nxt   = op_rd;
        wb_data_nxt = load_extend(op_size, op_unsigned, op_alu[1:0], dmem_rdata);
        wb_we_nxt   = (op_rd != '0);
      end
      default: wb_load = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && src_mem && !src_mis) begin
            state      <= ST_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= src_store;
            dmem_addr  <= {src_alu[XLEN-1:2], 2'b00};
            dmem_wdata <= store_data(src_size, src_rs2);
            dmem_wstrb <= src_store ? store_strobe(src_size, src_alu[1:0]) : 4'b0000;
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            state      <= op_load ? ST_RESP : ST_IDLE;
          end
        end
        ST_RESP: begin
          if (dmem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: capture registers carry no reset; they are only read after an accept has loaded them.
  always_ff @(posedge aclk) begin
    if (accept) begin
      op_load     <= src_load;
      op_size     <= src_size;
      op_unsigned <= src_unsigned;
      op_rd       <= src_rd;
      op_alu      <= src_alu;
    end
  end

  // Writeback register: holds while stalled, empties on handshake unless reloaded.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wb_tvalid  <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
    end else if (wb_load) begin
      wb_tvalid  <= 1'b1;
      wb_rd      <= wb_rd_nxt;
      wb_data    <= wb_data_nxt;
      wb_we      <= wb_we_nxt;
      misaligned <= wb_mis_nxt;
    end else if (wb_tready) begin
      wb_tvalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed instructions, an in-order
// expectation model for bus requests and writeback beats, and literal spot checks.
module tb_memory_access;

  logic        aclk = 1'b0;
  logic        areset;
  logic        src_tvalid, src_tready, src_load, src_store, src_unsigned;
  logic [1:0]  src_size;
  logic [4:0]  src_rd;
  logic [31:0] src_alu, src_rs2;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_tvalid, wb_tready, wb_we, misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, bypass;

  memory_access dut (
    .aclk(aclk), .areset(areset),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_load(src_load),
    .src_store(src_store), .src_size(src_size), .src_unsigned(src_unsigned),
    .src_rd(src_rd), .src_alu(src_alu), .src_rs2(src_rs2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_tvalid(wb_tvalid), .wb_tready(wb_tready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_we(wb_we), .misaligned(misaligned), .bypass(bypass)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        mis;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  wb_exp_t  we_e;
  req_exp_t rq_e;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int beats = 0;
  int reqs = 0;
  int req_cycles = 0;
  int last_req_cycles = 0;
  logic [31:0] last_wb_data, last_req_addr, last_req_wdata;
  logic        last_wb_we, last_wb_mis;
  logic [3:0]  last_req_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge aclk) cyc++;

  // Expected behaviour of one instruction, from the architectural rules.
  task automatic expect_instr(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                              input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                              input logic [31:0] rdata);
    int off, sz, bits, nbytes;
    bit mem, mis;
    longint unsigned sh, v;
    wb_exp_t w;
    req_exp_t r;
    off = int'(alu % 4);
    sz  = (size == 2'd3) ? 2 : int'(size);
    mem = ld | st;
    mis = mem && ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0));
    if (!mem || mis) begin
      w = '{rd, alu, (!mem && rd != 0), mis, 1'b1};
      wb_q.push_back(w);
    end else begin
      nbytes  = 1 << sz;
      r.addr  = alu - 32'(off);
      r.we    = st;
      r.wstrb = st ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
      if (sz == 0)      r.wdata = 32'(rs2[7:0]) * 32'h0101_0101;
      else if (sz == 1) r.wdata = 32'(rs2[15:0]) * 32'h0001_0001;
      else              r.wdata = rs2;
      req_q.push_back(r);
      if (st) begin
        w = '{rd, 32'h0, 1'b0, 1'b0, 1'b0};
      end else begin
        bits = 8 * nbytes;
        sh = {32'd0, rdata} >> (8 * off);
        v  = sh % (64'd1 << bits);
        if (!uns && bits < 32 && v >= (64'd1 << (bits - 1)))
          v = v + (64'd1 << 32) - (64'd1 << bits);
        w = '{rd, v[31:0], (rd != 0), 1'b0, 1'b1};
      end
      wb_q.push_back(w);
    end
  endtask

  // Compare process: every cycle outputs are meaningful, check against the model.
  always @(negedge aclk) begin
    if (!areset) begin
      if (wb_tvalid) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected_beat", 32'(wb_tvalid), 32'd0);
        end else begin
          we_e = wb_q[0];
          check("wb_rd", 32'(wb_rd), 32'(we_e.rd));
          check("wb_we", 32'(wb_we), 32'(we_e.we));
          check("wb_misaligned", 32'(misaligned), 32'(we_e.mis));
          if (we_e.chk_data) begin
            check("wb_data", wb_data, we_e.data);
            check("bypass", bypass, we_e.data);
          end
          if (wb_tready) begin
            last_wb_data = wb_data;
            last_wb_we   = wb_we;
            last_wb_mis  = misaligned;
            beats++;
            void'(wb_q.pop_front());
          end
        end
      end
      if (dmem_req) begin
        req_cycles++;
        if (req_q.size() == 0) begin
          check("dmem_unexpected_req", 32'(dmem_req), 32'd0);
        end else begin
          rq_e = req_q[0];
          check("dmem_addr", dmem_addr, rq_e.addr);
          check("dmem_we", 32'(dmem_we), 32'(rq_e.we));
          check("dmem_wstrb", 32'(dmem_wstrb), 32'(rq_e.wstrb));
          if (rq_e.we) check("dmem_wdata", dmem_wdata, rq_e.wdata);
          if (dmem_gnt) begin
            last_req_cycles = req_cycles;
            last_req_addr   = dmem_addr;
            last_req_wdata  = dmem_wdata;
            last_req_wstrb  = dmem_wstrb;
            req_cycles      = 0;
            reqs++;
            void'(req_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                      input logic [31:0] rdata);
    bit done = 1'b0;
    expect_instr(ld, st, size, uns, rd, alu, rs2, rdata);
    src_load = ld; src_store = st; src_size = size; src_unsigned = uns;
    src_rd = rd; src_alu = alu; src_rs2 = rs2; src_tvalid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      if (src_tready) begin
        @(posedge aclk); #1;
        done = 1'b1;
      end
    end
    src_tvalid = 1'b0;
    if (!done) check("src_accept_timeout", 32'(done), 32'd1);
  endtask

  // Memory responder for one access; optional rvalid pulses while still ungranted.
  task automatic serve(input int gnt_delay, input bit ld, input int rv_delay,
                       input logic [31:0] rdata, input bit spurious);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge aclk);
      if (dmem_req) seen = 1'b1;
    end
    if (!seen) begin
      check("dmem_req_timeout", 32'(seen), 32'd1);
      return;
    end
    repeat (gnt_delay) begin
      @(posedge aclk); #1;
      if (spurious) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_DEAD; end
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = rdata;
    dmem_gnt    = 1'b1;
    @(posedge aclk); #1;
    dmem_gnt = 1'b0;
    if (ld && rv_delay > 0) begin
      repeat (rv_delay - 1) begin @(posedge aclk); #1; end
      dmem_rvalid = 1'b1;
      @(posedge aclk); #1;
      dmem_rvalid = 1'b0;
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(posedge aclk); #2;
      empty = (wb_q.size() == 0) && (req_q.size() == 0);
    end
    if (!empty) check("drain_timeout", 32'(empty), 32'd1);
    @(posedge aclk); #1;
  endtask

  task automatic mem_op(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int gnt_delay, input int rv_delay,
                        input bit spurious);
    fork
      send(ld, st, size, uns, rd, alu, rs2, rdata);
      serve(gnt_delay, ld, rv_delay, rdata, spurious);
    join
    drain();
  endtask

  int c0, b0, r0;

  initial begin
    areset = 1'b1;
    src_tvalid = 0; src_load = 0; src_store = 0; src_size = 0; src_unsigned = 0;
    src_rd = 0; src_alu = 0; src_rs2 = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; wb_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Reset state
    check("rst_wb_tvalid", 32'(wb_tvalid), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_src_tready", 32'(src_tready), 32'd1);

    // ALU op: latency 1
    send(0, 0, 2'd0, 0, 5'd5, 32'h1234, 32'h0, 32'h0);
    check("alu_latency_valid", 32'(wb_tvalid), 32'd1);
    drain();
    check("alu_data", last_wb_data, 32'h0000_1234);
    check("alu_we", 32'(last_wb_we), 32'd1);
    send(0, 0, 2'd2, 0, 5'd0, 32'h55, 32'h0, 32'h0);
    drain();
    check("alu_rd0_we", 32'(last_wb_we), 32'd0);

    // Back-to-back throughput
    c0 = cyc;
    send(0, 0, 2'd0, 0, 5'd1, 32'h11, 32'h0, 32'h0);
    send(0, 0, 2'd0, 0, 5'd2, 32'h22, 32'h0, 32'h0);
    send(0, 0, 2'd0, 0, 5'd3, 32'h33, 32'h0, 32'h0);
    check("b2b_cycles", 32'(cyc - c0), 32'd3);
    drain();

    // Stores
    mem_op(0, 1, 2'd0, 0, 5'd4, 32'h103, 32'hAB, 32'h0, 2, 0, 0);
    check("sb_addr", last_req_addr, 32'h100);
    check("sb_wstrb", 32'(last_req_wstrb), 32'h8);
    check("sb_wdata", last_req_wdata, 32'hABAB_ABAB);
    check("sb_req_cycles", 32'(last_req_cycles), 32'd3);
    check("sb_wb_we", 32'(last_wb_we), 32'd0);
    mem_op(0, 1, 2'd1, 0, 5'd6, 32'h10A, 32'h1234_CDEF, 32'h0, 1, 0, 0);
    check("sh_wstrb", 32'(last_req_wstrb), 32'hC);
    mem_op(0, 1, 2'd3, 0, 5'd7, 32'h20, 32'hDEAD_BEEF, 32'h0, 1, 0, 0);

    // Loads, with ungranted rvalid pulses that must be ignored
    mem_op(1, 0, 2'd1, 0, 5'd8, 32'h202, 32'h0, 32'h8001_0000, 2, 3, 1);
    check("lh_data", last_wb_data, 32'hFFFF_8001);
    mem_op(1, 0, 2'd1, 1, 5'd9, 32'h202, 32'h0, 32'h8001_0000, 1, 3, 0);
    check("lhu_data", last_wb_data, 32'h0000_8001);
    mem_op(1, 0, 2'd0, 0, 5'd10, 32'h401, 32'h0, 32'h0000_8000, 1, 1, 0);
    check("lb_data", last_wb_data, 32'hFFFF_FF80);
    mem_op(1, 0, 2'd0, 1, 5'd0, 32'h401, 32'h0, 32'h0000_8000, 1, 2, 0);
    check("lbu_rd0_we", 32'(last_wb_we), 32'd0);
    mem_op(1, 0, 2'd3, 0, 5'd11, 32'h500, 32'h0, 32'h1234_5678, 1, 1, 1);

    // Misaligned accesses: no bus request
    r0 = reqs;
    send(1, 0, 2'd2, 0, 5'd12, 32'h301, 32'h0, 32'h0);
    drain();
    check("lw_mis_flag", 32'(last_wb_mis), 32'd1);
    check("lw_mis_data", last_wb_data, 32'h301);
    send(0, 1, 2'd1, 0, 5'd13, 32'h11, 32'h5555, 32'h0);
    drain();
    check("mis_no_req", 32'(reqs - r0), 32'd0);

    // Writeback backpressure
    b0 = beats;
    wb_tready = 1'b0;
    fork
      begin
        send(0, 0, 2'd0, 0, 5'd14, 32'h700, 32'h0, 32'h0);
        send(0, 0, 2'd0, 0, 5'd15, 32'h701, 32'h0, 32'h0);
        send(0, 0, 2'd0, 0, 5'd16, 32'h702, 32'h0, 32'h0);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge aclk);
          seen = wb_tvalid;
        end
        check("bp_first_beat", 32'(seen), 32'd1);
        check("bp_stall_tready", 32'(src_tready), 32'd0);
        @(negedge aclk);
        check("bp_stall_tready2", 32'(src_tready), 32'd0);
        check("bp_hold_data", wb_data, 32'h700);
        @(posedge aclk); #1;
        wb_tready = 1'b1;
      end
    join
    drain();
    check("bp_beats", 32'(beats - b0), 32'd3);

    // Reset while waiting for load data
    fork
      send(1, 0, 2'd2, 0, 5'd17, 32'h600, 32'h0, 32'h0);
      serve(1, 1, 0, 32'hCAFE_F00D, 0);
    join
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    wb_q.delete();
    req_q.delete();
    dmem_rvalid = 1'b1;
    @(posedge aclk); #1;
    dmem_rvalid = 1'b0;
    check("rstmid_dmem_req", 32'(dmem_req), 32'd0);
    check("rstmid_src_tready", 32'(src_tready), 32'd1);
    check("rstmid_wb_tvalid", 32'(wb_tvalid), 32'd0);
    repeat (3) @(posedge aclk);
    #1;
    check("rstmid_wb_tvalid_late", 32'(wb_tvalid), 32'd0);

    // Pipeline still works after the mid-access reset
    send(0, 0, 2'd0, 0, 5'd18, 32'h9999, 32'h0, 32'h0);
    drain();
    check("post_rst_alu", last_wb_data, 32'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
